// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for the 16x-oversampled UART: byte strobe detection,
// first-word-fall-through FIFO with overflow flag, and idle-timeout message framing.
module uart_rx_ctrl #(
    parameter int DEPTH      = 8,
    parameter int IDLE_TICKS = 320
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_received,
    input  logic [7:0]               rx_data,
    input  logic                     enable,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     msg_end,
    output logic [7:0]               msg_len
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(IDLE_TICKS);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] LAST_TICK = TW'(IDLE_TICKS - 1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_rx_prev;
    logic          r_overflow;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_len;
    logic          r_msg_end;
    logic [7:0]    r_msg_len;
    state_t        r_state;
    state_t        w_state_nxt;

    logic w_strb;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_timeout;

    assign w_strb = rx_received & ~r_rx_prev & enable;
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = m_valid & m_ready;
    assign w_push = w_strb & (~w_full | w_pop);

    assign m_valid    = (r_count != '0);
    // Head is forced to zero when empty so stale entries never appear on the bus.
    assign m_data     = m_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign msg_end    = r_msg_end;
    assign msg_len    = r_msg_len;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_rx_prev  <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_rx_prev <= rx_received;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh drop takes priority over a clear in the same cycle.
            if (w_strb && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strb) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!w_strb && r_timer == LAST_TICK) begin
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_len     <= '0;
            r_msg_end <= 1'b0;
            r_msg_len <= '0;
        end else begin
            r_msg_end <= w_timeout;
            if (w_strb) begin
                r_timer <= '0;
                r_len   <= (r_state == S_IDLE) ? 8'd1 : sat_inc(r_len);
            end else if (w_timeout) begin
                r_timer   <= '0;
                r_msg_len <= r_len;
            end else if (r_state == S_ACTIVE) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: byte queue scoreboard, overflow, idle-timeout
// framing and mid-operation reset.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_received = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       enable = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic       msg_end;
    logic [7:0] msg_len;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    uart_rx_ctrl #(.DEPTH(8), .IDLE_TICKS(320)) dut (
        .clk(clk), .rst_n(rst_n), .rx_received(rx_received), .rx_data(rx_data),
        .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow),
        .msg_end(msg_end), .msg_len(msg_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Strobe edge is the posedge right after rx_received rises; returns at the
    // following negedge.
    task automatic send(input logic [7:0] b, input bit drop);
        rx_received = 1'b0;
        rx_data     = b;
        @(negedge clk);
        rx_received = 1'b1;
        if (!drop && enable) sb.push_back(b);
        @(negedge clk);
    endtask

    task automatic do_pop();
        chk("pop_valid", m_valid, 1'b1);
        chk("pop_data", m_data, sb[0]);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        void'(sb.pop_front());
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            do_pop();
            guard++;
        end
        chk("drain_empty", m_valid, 1'b0);
        chk("drain_count", fifo_count, 0);
    endtask

    initial begin
        int pulses;
        int pulse_at;
        logic [7:0] len_at;

        // Reset values and quiet line
        #3;
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_msg_end", msg_end, 1'b0);
        chk("rst_msg_len", msg_len, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (msg_end || m_valid || fifo_count != 0) pulses++;
        end
        chk("idle50_quiet", pulses, 0);

        // Single byte and one-cycle pop
        send(8'hA5, 0);
        chk("t2_valid", m_valid, 1'b1);
        chk("t2_data", m_data, 8'hA5);
        chk("t2_count", fifo_count, 1);
        do_pop();
        chk("t2_count0", fifo_count, 0);
        chk("t2_valid0", m_valid, 1'b0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("underflow_count", fifo_count, 0);

        // Fill, overflow, ordered drain, clear
        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        chk("t3_full", fifo_count, 8);
        chk("t3_no_ovf", overflow, 1'b0);
        send(8'h09, 1);
        chk("t3_count", fifo_count, 8);
        chk("t3_ovf", overflow, 1'b1);
        drain();
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("t3_clr", overflow, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 0);
        chk("t4_full", fifo_count, 8);
        rx_received = 1'b0;
        @(negedge clk);
        rx_received = 1'b1;
        rx_data     = 8'h55;
        m_ready     = 1'b1;
        chk("t4_head", m_data, sb[0]);
        void'(sb.pop_front());
        sb.push_back(8'h55);
        @(negedge clk);
        m_ready = 1'b0;
        chk("t4_count", fifo_count, 8);
        chk("t4_ovf", overflow, 1'b0);
        drain();

        // Completed byte while disabled is discarded
        enable = 1'b0;
        send(8'h77, 0);
        enable = 1'b1;
        chk("dis_count", fifo_count, 0);

        // Framing: let any open message close, then 3 bytes spaced 160 cycles
        repeat (340) @(negedge clk);
        send(8'h10, 0);
        repeat (158) @(negedge clk);
        send(8'h20, 0);
        repeat (158) @(negedge clk);
        send(8'h30, 0);
        pulses   = 0;
        pulse_at = -1;
        len_at   = 8'h00;
        for (int i = 1; i <= 340; i++) begin
            @(negedge clk);
            if (msg_end) begin
                pulses++;
                pulse_at = i;
                len_at   = msg_len;
            end
        end
        chk("t5_pulses", pulses, 1);
        chk("t5_pulse_at", pulse_at, 320);
        chk("t5_len", len_at, 8'd3);
        chk("t5_count", fifo_count, 3);
        drain();

        // Reset in the middle of an open message
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 0);
        chk("t6_count_pre", fifo_count, 4);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("t6_count", fifo_count, 0);
        chk("t6_valid", m_valid, 1'b0);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_data", m_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (msg_end) pulses++;
        end
        chk("t6_no_msg_end", pulses, 0);
        chk("t6_valid_after", m_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
